// File: rtl/md_issue_ctrl.sv
// -----------------------------------------------------------------------------
// md_issue_ctrl
//
// Issue and sequencing controller for the multiply/divide datapath of the
// pipelined MIPS core. It sits at the E stage and does the following:
//   - decodes the E-stage HI/LO operation;
//   - issues a one-cycle start to the MD datapath;
//   - times the operation latency with a private down-counter;
//   - stalls the D stage for any HI/LO-touching instruction while the unit is
//     occupied;
//   - masks new issue (and mthi/mtlo writes) while an exception/interrupt flush
//     request is high.
//
// Parameters:
//   MULT_CYCLES  busy cycles for mult/multu (1..15)
//   DIV_CYCLES   busy cycles for div/divu   (1..15)
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high reset
//   req        exception/interrupt flush request; masks issue this cycle
//   e_valid    E-stage instruction valid
//   e_op       E-stage HI/LO op:
//                0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo,
//                7 reserved (treated as none)
//   d_md_use   D-stage instruction touches HI/LO
//   md_start   one-cycle issue pulse (the datapath samples operands this cycle)
//   md_op      op latched at issue, held until the next issue
//   hi_we      mthi write pulse
//   lo_we      mtlo write pulse
//   md_done    one-cycle pulse in the final busy cycle
//   busy       operation in flight
//   stall_d    stall the D stage
//   proto_err  sticky flag: an E-stage MD/MT op arrived while busy
//
// Optional build macro MD_PERF_EN adds two free-running 32-bit counters:
//   perf_stall  cycles with stall_d high
//   perf_ops    number of md_start pulses
// -----------------------------------------------------------------------------
module md_issue_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        e_valid,
  input  logic [2:0]  e_op,
  input  logic        d_md_use,
  output logic        md_start,
  output logic [2:0]  md_op,
  output logic        hi_we,
  output logic        lo_we,
  output logic        md_done,
  output logic        busy,
  output logic        stall_d,
  output logic        proto_err
`ifdef MD_PERF_EN
  ,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_ops
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [3:0] MULT_LAT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LAT  = 4'(DIV_CYCLES);

  state_t     state;
  logic [3:0] cnt;

  logic       is_md;
  logic       is_mt;
  logic       is_mul;
  logic       issue_ok;
  logic [3:0] lat;

  // Op decode. Ops 0 and 7 fall out of every class, so they never act.
  assign is_md  = (e_op >= 3'd1) && (e_op <= 3'd4);
  assign is_mt  = (e_op == 3'd5) || (e_op == 3'd6);
  assign is_mul = (e_op == 3'd1) || (e_op == 3'd2);
  assign lat    = is_mul ? MULT_LAT : DIV_LAT;

  // Anything that commits from the E stage must be valid, must not be flushed,
  // and may only be accepted while the unit is free.
  assign issue_ok = e_valid & ~req & (state == IDLE);

  assign md_start = issue_ok & is_md;
  assign hi_we    = issue_ok & (e_op == 3'd5);
  assign lo_we    = issue_ok & (e_op == 3'd6);

  // md_start is included so that the D-stage instruction already stalls in
  // the issue cycle, before busy has risen.
  assign stall_d  = d_md_use & (md_start | busy);

  // NOTE: sequential state is updated with non-blocking assignments so that
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      md_op     <= '0;
      busy      <= 1'b0;
      md_done   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (md_start) begin
            state   <= BUSY;
            md_op   <= e_op;
            cnt     <= lat;
            busy    <= 1'b1;
            // A one-cycle latency finishes in the very first busy cycle.
            md_done <= (lat == 4'd1);
          end
        end

        BUSY: begin
          if (cnt == 4'd1) begin
            state   <= IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
            md_done <= 1'b0;
          end else begin
            cnt     <= cnt - 4'd1;
            // md_done is registered: raise it for the cycle in which cnt
            // will read 1, i.e. the last busy cycle.
            md_done <= (cnt == 4'd2);
          end
          // A correct pipeline stalls HI/LO users in D, so any MD/MT op that
          // reaches E now is a protocol violation. The op itself is dropped
          // because issue_ok is low in BUSY.
          if (e_valid && (is_md || is_mt)) begin
            proto_err <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef MD_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall <= '0;
      perf_ops   <= '0;
    end else begin
      if (stall_d) perf_stall <= perf_stall + 32'd1;
      if (md_start) perf_ops  <= perf_ops + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_md_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_md_issue_ctrl
//
// Self-checking bench for md_issue_ctrl. It runs three phases:
//   - a directed vector table applied cycle by cycle;
//   - hand-written multi-cycle sequences for the latency, stall, flush,
//     protocol-error and reset corner cases;
//   - randomized traffic compared against a timestamp-based reference model.
// Inputs change 1 time unit after the rising edge. Outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_md_issue_ctrl;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       req;
  logic       e_valid;
  logic [2:0] e_op;
  logic       d_md_use;

  logic       md_start;
  logic [2:0] md_op;
  logic       hi_we;
  logic       lo_we;
  logic       md_done;
  logic       busy;
  logic       stall_d;
  logic       proto_err;
`ifdef MD_PERF_EN
  logic [31:0] perf_stall;
  logic [31:0] perf_ops;
`endif

  always #5 clk = ~clk;

  md_issue_ctrl #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .e_valid   (e_valid),
    .e_op      (e_op),
    .d_md_use  (d_md_use),
    .md_start  (md_start),
    .md_op     (md_op),
    .hi_we     (hi_we),
    .lo_we     (lo_we),
    .md_done   (md_done),
    .busy      (busy),
    .stall_d   (stall_d),
    .proto_err (proto_err)
`ifdef MD_PERF_EN
    ,
    .perf_stall(perf_stall),
    .perf_ops  (perf_ops)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs, then wait for the sampling point.
  task automatic apply(input logic r, input logic q, input logic v,
                       input logic [2:0] op, input logic d);
    reset    = r;
    req      = q;
    e_valid  = v;
    e_op     = op;
    d_md_use = d;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    apply(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    tick();
  endtask

  // Output bit order: {md_start, hi_we, lo_we, busy, md_done, stall_d, proto_err}.
  function automatic logic [6:0] outs();
    return {md_start, hi_we, lo_we, busy, md_done, stall_d, proto_err};
  endfunction

  typedef struct {
    logic       req;
    logic       e_valid;
    logic [2:0] e_op;
    logic       d_md_use;
    logic [6:0] exp;
    logic [2:0] exp_op;
  } vec_t;

  // Reference-model state. An operation is represented only by the cycle it
  // was issued in and its latency; "in flight" is then a window test.
  int         m_cyc;
  int         m_issue;
  int         m_lat;
  logic [2:0] m_op;
  bit         m_perr;
  logic [31:0] m_pstall;
  logic [31:0] m_pops;

  initial begin
    vec_t tbl[19];
    reset = 1'b1; req = 1'b0; e_valid = 1'b0; e_op = 3'd0; d_md_use = 1'b0;
    tick();
    do_reset();

    // ---------------- directed vector table ----------------
    tbl[0]  = '{1'b0, 1'b1, 3'd1, 1'b0, 7'b1000000, 3'd0};  // mult issue
    tbl[1]  = '{1'b0, 1'b0, 3'd0, 1'b1, 7'b0001010, 3'd1};  // busy 1, D user stalls
    tbl[2]  = '{1'b0, 1'b0, 3'd0, 1'b0, 7'b0001000, 3'd1};
    tbl[3]  = '{1'b0, 1'b0, 3'd0, 1'b0, 7'b0001000, 3'd1};
    tbl[4]  = '{1'b0, 1'b0, 3'd0, 1'b0, 7'b0001000, 3'd1};
    tbl[5]  = '{1'b0, 1'b0, 3'd0, 1'b1, 7'b0001110, 3'd1};  // busy 5 + done
    tbl[6]  = '{1'b0, 1'b1, 3'd5, 1'b0, 7'b0100000, 3'd1};  // mthi in IDLE
    tbl[7]  = '{1'b0, 1'b1, 3'd6, 1'b0, 7'b0010000, 3'd1};  // mtlo
    tbl[8]  = '{1'b1, 1'b1, 3'd3, 1'b0, 7'b0000000, 3'd1};  // div masked by req
    tbl[9]  = '{1'b1, 1'b1, 3'd5, 1'b0, 7'b0000000, 3'd1};  // mthi masked by req
    tbl[10] = '{1'b0, 1'b1, 3'd7, 1'b1, 7'b0000000, 3'd1};  // reserved op
    tbl[11] = '{1'b0, 1'b0, 3'd1, 1'b1, 7'b0000000, 3'd1};  // invalid
    tbl[12] = '{1'b0, 1'b1, 3'd2, 1'b1, 7'b1000010, 3'd1};  // multu issue + stall
    tbl[13] = '{1'b0, 1'b0, 3'd0, 1'b0, 7'b0001000, 3'd2};
    tbl[14] = '{1'b0, 1'b0, 3'd0, 1'b0, 7'b0001000, 3'd2};
    tbl[15] = '{1'b0, 1'b0, 3'd0, 1'b0, 7'b0001000, 3'd2};
    tbl[16] = '{1'b0, 1'b0, 3'd0, 1'b0, 7'b0001000, 3'd2};
    tbl[17] = '{1'b0, 1'b0, 3'd0, 1'b0, 7'b0001100, 3'd2};  // done
    tbl[18] = '{1'b0, 1'b0, 3'd0, 1'b0, 7'b0000000, 3'd2};  // back to IDLE

    for (int i = 0; i < 19; i++) begin
      apply(1'b0, tbl[i].req, tbl[i].e_valid, tbl[i].e_op, tbl[i].d_md_use);
      check($sformatf("tbl[%0d].outs", i), 32'(outs()), 32'(tbl[i].exp));
      check($sformatf("tbl[%0d].md_op", i), 32'(md_op), 32'(tbl[i].exp_op));
      tick();
    end

    // ---------------- divu with D-stage mflo held ----------------
    do_reset();
    apply(1'b0, 1'b0, 1'b1, 3'd4, 1'b1);
    check("divu.c0.stall", 32'(stall_d), 32'd1);
    check("divu.c0.start", 32'(md_start), 32'd1);
    tick();
    for (int c = 1; c <= 11; c++) begin
      apply(1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
      check($sformatf("divu.c%0d.stall", c), 32'(stall_d), (c <= DIV_CYCLES) ? 32'd1 : 32'd0);
      check($sformatf("divu.c%0d.done", c), 32'(md_done), (c == DIV_CYCLES) ? 32'd1 : 32'd0);
      tick();
    end
    check("divu.md_op", 32'(md_op), 32'd4);

    // ---------------- mult with protocol error and mid-op req ----------------
    do_reset();
    for (int c = 0; c <= 6; c++) begin
      case (c)
        0:       apply(1'b0, 1'b0, 1'b1, 3'd1, 1'b0);
        2:       apply(1'b0, 1'b0, 1'b1, 3'd2, 1'b0);
        3:       apply(1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
        default: apply(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
      endcase
      check($sformatf("perr.c%0d.done", c), 32'(md_done), (c == MULT_CYCLES) ? 32'd1 : 32'd0);
      check($sformatf("perr.c%0d.proto_err", c), 32'(proto_err), (c >= 3) ? 32'd1 : 32'd0);
      if (c == 2) check("perr.c2.start", 32'(md_start), 32'd0);
      tick();
    end
    check("perr.md_op", 32'(md_op), 32'd1);
    do_reset();
    apply(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    check("perr.cleared", 32'(proto_err), 32'd0);
    tick();

    // ---------------- reset in the middle of a divide ----------------
    do_reset();
    apply(1'b0, 1'b0, 1'b1, 3'd3, 1'b0);  // cycle 0: div issue
    tick();
    for (int c = 1; c <= 3; c++) begin
      apply(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
      tick();
    end
    apply(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);  // cycle 4: reset
    check("rst.c4.busy", 32'(busy), 32'd1);
    tick();
    apply(1'b0, 1'b0, 1'b1, 3'd1, 1'b0);  // cycle 5: new mult
    check("rst.c5.outs", 32'(outs()), 32'(7'b1000000));
    check("rst.c5.md_op", 32'(md_op), 32'd0);
`ifdef MD_PERF_EN
    check("rst.c5.perf_stall", perf_stall, 32'd0);
    check("rst.c5.perf_ops", perf_ops, 32'd0);
`endif
    tick();
    for (int c = 6; c <= 11; c++) begin
      apply(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
      check($sformatf("rst.c%0d.busy", c), 32'(busy), (c <= 10) ? 32'd1 : 32'd0);
      check($sformatf("rst.c%0d.done", c), 32'(md_done), (c == 10) ? 32'd1 : 32'd0);
      tick();
    end
    check("rst.md_op", 32'(md_op), 32'd1);

    // ---------------- randomized traffic vs reference model ----------------
    do_reset();
    m_cyc = 0; m_issue = -1; m_lat = 0; m_op = 3'd0; m_perr = 1'b0;
    m_pstall = '0; m_pops = '0;
    for (int n = 0; n < 4000; n++) begin
      logic       r, q, v, d;
      logic [2:0] op;
      bit         in_flight, e_start, e_hi, e_lo, e_done, e_stall;
      r  = ($urandom_range(63) == 0);
      q  = ($urandom_range(7) == 0);
      v  = $urandom_range(1);
      op = 3'($urandom_range(7));
      d  = $urandom_range(1);

      in_flight = (m_issue >= 0) && (m_cyc > m_issue) && (m_cyc <= m_issue + m_lat);
      e_done    = in_flight && (m_cyc == m_issue + m_lat);
      e_start   = !in_flight && v && !q && (op >= 1) && (op <= 4);
      e_hi      = !in_flight && v && !q && (op == 5);
      e_lo      = !in_flight && v && !q && (op == 6);
      e_stall   = d && (e_start || in_flight);

      apply(r, q, v, op, d);
      check($sformatf("rnd[%0d].outs", n), 32'(outs()),
            32'({e_start, e_hi, e_lo, in_flight, e_done, e_stall, m_perr}));
      check($sformatf("rnd[%0d].md_op", n), 32'(md_op), 32'(m_op));
`ifdef MD_PERF_EN
      check($sformatf("rnd[%0d].perf_stall", n), perf_stall, m_pstall);
      check($sformatf("rnd[%0d].perf_ops", n), perf_ops, m_pops);
`endif
      tick();

      // Model update at the clock edge.
      if (r) begin
        m_issue  = -1;
        m_op     = 3'd0;
        m_perr   = 1'b0;
        m_pstall = '0;
        m_pops   = '0;
      end else begin
        if (in_flight && v && (op >= 1) && (op <= 6)) m_perr = 1'b1;
        if (e_start) begin
          m_issue = m_cyc;
          m_lat   = (op <= 2) ? MULT_CYCLES : DIV_CYCLES;
          m_op    = op;
          m_pops  = m_pops + 32'd1;
        end
        if (e_stall) m_pstall = m_pstall + 32'd1;
      end
      m_cyc++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
